// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank and its response FIFOs.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  // True when addr is stride-aligned and falls inside [base, base + count*stride).
  // The base is expected to be aligned to count*stride, so checking addr alone
  // for stride alignment is sufficient.
  function automatic logic addr_legal(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] count,
    input logic [63:0] stride
  );
    logic [63:0] offset;
    offset = addr - base;
    return (addr >= base) &&
           (offset < (count * stride)) &&
           ((addr & (stride - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/axi4_lite_resp_fifo.sv
// Two-entry valid/ready response buffer. The head entry drives valid and the
// payload, so the payload is stable for as long as valid is held without ready.
// The producer only pushes while count is below two.
module axi4_lite_resp_fifo #(
  parameter int WIDTH = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             pop;

  assign valid = (count != 2'd0);
  assign pop   = valid && ready;
  assign data  = mem[rd_ptr];

  // Storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/axi4_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank with independent two-entry B and R
// response buffers and a hardware-side port for status updates and write strobes.
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int                      ADDR_WIDTH = 32,
  parameter int                      DATA_WIDTH = 32,
  parameter int                      NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
  parameter logic [NUM_REGS-1:0]     RO_MASK    = '0,
  localparam int                     STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  input  logic [NUM_REGS-1:0]            hw_we,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int LANE_W = $clog2(STRB_WIDTH);
  localparam int IDX_W  = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  commit;
  logic                  wr_legal;
  logic                  wr_ok;
  logic [IDX_W-1:0]      wr_idx;
  resp_e                 wr_resp;
  logic [1:0]            b_push_data;
  logic [1:0]            b_data;
  logic [1:0]            b_count;

  logic                  ar_hs;
  logic                  rd_legal;
  logic [IDX_W-1:0]      rd_idx;
  resp_e                 rd_resp;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH+1:0] r_push_data;
  logic [DATA_WIDTH+1:0] r_data;
  logic [1:0]            r_count;

  assign awready = !aw_full;
  assign wready  = !w_full;
  assign commit  = aw_full && w_full && (b_count < 2'd2);
  assign arready = (r_count < 2'd2);
  assign ar_hs   = arvalid && arready;

  // Decode the held write address into a register index and response.
  always_comb begin
    wr_legal    = addr_legal(64'(aw_addr_q), 64'(BASE_ADDR), 64'(NUM_REGS), 64'(STRB_WIDTH));
    wr_idx      = IDX_W'((64'(aw_addr_q) - 64'(BASE_ADDR)) >> LANE_W);
    wr_ok       = wr_legal && !RO_MASK[wr_idx];
    wr_resp     = wr_ok ? OKAY : SLVERR;
    b_push_data = wr_resp;
  end

  // Decode the read address and sample the register value in the handshake cycle.
  always_comb begin
    rd_legal    = addr_legal(64'(araddr), 64'(BASE_ADDR), 64'(NUM_REGS), 64'(STRB_WIDTH));
    rd_idx      = IDX_W'((64'(araddr) - 64'(BASE_ADDR)) >> LANE_W);
    rd_data     = rd_legal ? regs[rd_idx] : '0;
    rd_resp     = rd_legal ? OKAY : SLVERR;
    r_push_data = {rd_resp, rd_data};
  end

  // AW and W holding slots fill independently and empty together on commit.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddr;
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (wvalid && wready) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  // Register file: a committed bus write to a register beats hw_we for it.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_ok && (wr_idx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb_q[b]) begin
              regs[i][8*b +: 8] <= w_data_q[8*b +: 8];
            end
          end
        end else if (hw_we[i]) begin
          regs[i] <= hw_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // One-cycle strobe for registers actually changed by a bus write.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit && wr_ok && (w_strb_q != '0)) begin
        wr_pulse[wr_idx] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  axi4_lite_resp_fifo #(
    .WIDTH (2)
  ) u_b_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (commit),
    .push_data (b_push_data),
    .valid     (bvalid),
    .ready     (bready),
    .data      (b_data),
    .count     (b_count)
  );

  axi4_lite_resp_fifo #(
    .WIDTH (DATA_WIDTH + 2)
  ) u_r_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (ar_hs),
    .push_data (r_push_data),
    .valid     (rvalid),
    .ready     (rready),
    .data      (r_data),
    .count     (r_count)
  );

  assign bresp = b_data;
  assign rresp = r_data[DATA_WIDTH+1 -: 2];
  assign rdata = r_data[DATA_WIDTH-1:0];

endmodule
